// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment types and active-low glyph constants (bit0 = a .. bit6 = g).
// Revision 1.0
`default_nettype none

package seg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0   = 7'b1000000;
   localparam seg_t SEG_1   = 7'b1111001;
   localparam seg_t SEG_2   = 7'b0100100;
   localparam seg_t SEG_3   = 7'b0110000;
   localparam seg_t SEG_4   = 7'b0011001;
   localparam seg_t SEG_5   = 7'b0010010;
   localparam seg_t SEG_6   = 7'b0000010;
   localparam seg_t SEG_7   = 7'b1111000;
   localparam seg_t SEG_8   = 7'b0000000;
   localparam seg_t SEG_9   = 7'b0010000;
   localparam seg_t SEG_A   = 7'b0001000;
   localparam seg_t SEG_B   = 7'b0000011;
   localparam seg_t SEG_C   = 7'b1000110;
   localparam seg_t SEG_D   = 7'b0100001;
   localparam seg_t SEG_E   = 7'b0000110;
   localparam seg_t SEG_F   = 7'b0001110;
   localparam seg_t SEG_OFF = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: datapath-side inputs and display-pin outputs of the scan driver.
// Revision 1.0
`default_nettype none

interface seven_seg_scan_if #(
   parameter int NUM_DIGITS = 4,
   parameter int BRIGHT_W   = 4
);
   logic [4*NUM_DIGITS-1:0] value_i;
   logic [NUM_DIGITS-1:0]   dp_i;
   logic [NUM_DIGITS-1:0]   blank_i;
   logic                    load_i;
   logic                    lzb_en_i;
   logic [BRIGHT_W-1:0]     brightness_i;
   logic [6:0]              seg_o;
   logic                    dp_o;
   logic [NUM_DIGITS-1:0]   an_o;
   logic                    frame_o;
   logic                    pending_o;

   modport master (
      output value_i, dp_i, blank_i, load_i, lzb_en_i, brightness_i,
      input  seg_o, dp_o, an_o, frame_o, pending_o
   );

   modport slave (
      input  value_i, dp_i, blank_i, load_i, lzb_en_i, brightness_i,
      output seg_o, dp_o, an_o, frame_o, pending_o
   );
endinterface

`default_nettype wire

// File: rtl/hex7_decode.sv
// hex7_decode: combinational nibble to active-low 7-segment glyph.
// Revision 1.0
`default_nettype none

module hex7_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       seg
);

   always_comb begin
      seg = SEG_OFF;
      case (nibble)
         4'h0:    seg = SEG_0;
         4'h1:    seg = SEG_1;
         4'h2:    seg = SEG_2;
         4'h3:    seg = SEG_3;
         4'h4:    seg = SEG_4;
         4'h5:    seg = SEG_5;
         4'h6:    seg = SEG_6;
         4'h7:    seg = SEG_7;
         4'h8:    seg = SEG_8;
         4'h9:    seg = SEG_9;
         4'hA:    seg = SEG_A;
         4'hB:    seg = SEG_B;
         4'hC:    seg = SEG_C;
         4'hD:    seg = SEG_D;
         4'hE:    seg = SEG_E;
         default: seg = SEG_F;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed N-digit 7-segment driver with tear-free shadow, PWM, DP and blanking.
// Revision 1.0
`default_nettype none

module seven_seg_scan
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int BRIGHT_W    = 4,
   parameter int ACTIVE_LOW  = 1
)(
   input  logic               clk,
   input  logic               rst_n,
   seven_seg_scan_if.slave    bus
);

   localparam int TW       = $clog2(REFRESH_DIV);
   localparam int IW       = $clog2(NUM_DIGITS);
   localparam int PWM_STEP = REFRESH_DIV >> BRIGHT_W;
   localparam logic [TW-1:0] TCNT_MAX = TW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] DIG_MAX  = IW'(NUM_DIGITS - 1);
   // Everything below is built active-low; POL flips it once at the pins.
   localparam logic POL = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

   logic [TW-1:0]           tcnt;
   logic [IW-1:0]           dig_idx;
   logic [4*NUM_DIGITS-1:0] stage_value, shadow_value;
   logic [NUM_DIGITS-1:0]   stage_dp, shadow_dp;
   logic [NUM_DIGITS-1:0]   stage_blank, shadow_blank;
   logic                    pending;

   logic [6:0]              seg_q;
   logic                    dp_q;
   logic [NUM_DIGITS-1:0]   an_q;
   logic                    frame_q;

   logic                    boundary;
   logic [NUM_DIGITS-1:0]   lzb_mask;
   logic                    lzb_run;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_dark;
   logic [NUM_DIGITS-1:0]   cur_sel;
   int                      lit_end;
   logic                    lit;
   logic                    on;
   seg_t                    glyph;
   seg_t                    seg_al;
   logic                    dp_al;
   logic [NUM_DIGITS-1:0]   an_al;

   assign boundary = (tcnt == TCNT_MAX) && (dig_idx == DIG_MAX);

   // Zero run from the MSD down; a set DP ends the run, digit 0 always shows.
   always_comb begin
      lzb_mask = '0;
      lzb_run  = bus.lzb_en_i;
      for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
         if (lzb_run && (shadow_value[4*d +: 4] == 4'h0) && !shadow_dp[d])
            lzb_mask[d] = 1'b1;
         else
            lzb_run = 1'b0;
      end
   end

   always_comb begin
      cur_nib  = 4'h0;
      cur_dp   = 1'b0;
      cur_dark = 1'b1;
      cur_sel  = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (dig_idx == IW'(d)) begin
            cur_nib  = shadow_value[4*d +: 4];
            cur_dp   = shadow_dp[d];
            cur_dark = shadow_blank[d] | lzb_mask[d];
            cur_sel  = NUM_DIGITS'(1) << d;
         end
      end
   end

   hex7_decode u_dec (
      .nibble (cur_nib),
      .seg    (glyph)
   );

   // tcnt==0 stays dark every slot so the previous digit's segments can settle.
   always_comb begin
      lit_end = (int'(bus.brightness_i) + 1) * PWM_STEP;
      lit     = (tcnt != '0) && (int'(tcnt) < lit_end);
      on      = lit && !cur_dark;
      seg_al  = on ? glyph : SEG_OFF;
      dp_al   = on ? ~cur_dp : 1'b1;
      an_al   = on ? ~cur_sel : '1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tcnt         <= '0;
         dig_idx      <= '0;
         stage_value  <= '0;
         stage_dp     <= '0;
         stage_blank  <= '0;
         shadow_value <= '0;
         shadow_dp    <= '0;
         shadow_blank <= '0;
         pending      <= 1'b0;
         seg_q        <= SEG_OFF ^ {7{POL}};
         dp_q         <= 1'b1 ^ POL;
         an_q         <= {NUM_DIGITS{1'b1 ^ POL}};
         frame_q      <= 1'b0;
      end else begin
         if (tcnt == TCNT_MAX) begin
            tcnt    <= '0;
            dig_idx <= (dig_idx == DIG_MAX) ? '0 : dig_idx + 1'b1;
         end else begin
            tcnt <= tcnt + 1'b1;
         end

         if (boundary) begin
            if (bus.load_i) begin
               shadow_value <= bus.value_i;
               shadow_dp    <= bus.dp_i;
               shadow_blank <= bus.blank_i;
            end else if (pending) begin
               shadow_value <= stage_value;
               shadow_dp    <= stage_dp;
               shadow_blank <= stage_blank;
            end
            pending <= 1'b0;
         end else if (bus.load_i) begin
            stage_value <= bus.value_i;
            stage_dp    <= bus.dp_i;
            stage_blank <= bus.blank_i;
            pending     <= 1'b1;
         end

         seg_q   <= seg_al ^ {7{POL}};
         dp_q    <= dp_al ^ POL;
         an_q    <= an_al ^ {NUM_DIGITS{POL}};
         frame_q <= boundary;
      end
   end

   assign bus.seg_o     = seg_q;
   assign bus.dp_o      = dp_q;
   assign bus.an_o      = an_q;
   assign bus.frame_o   = frame_q;
   assign bus.pending_o = pending;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: table-driven frame checks with a scoreboard queue for seven_seg_scan.
// Revision 1.0
`default_nettype none

module tb_seven_seg_scan;

   localparam int N   = 4;
   localparam int RD  = 16;
   localparam int BW  = 2;
   localparam int FRM = N * RD;

   typedef struct {
      logic [15:0]     value;
      logic [3:0]      dp;
      logic [3:0]      blank;
      logic            lzb;
      logic [1:0]      bright;
      logic [3:0][6:0] glyph;   // [d] = expected active-low glyph of digit d
      logic [3:0]      dark;    // digits expected to stay dark all slot
   } vec_t;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       frame;
      logic       pend;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   tests  = 0;
   int   failed = 0;
   exp_t sb[$];
   vec_t vecs[11];
   vec_t zero_v;

   seven_seg_scan_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) bus ();

   seven_seg_scan #(
      .NUM_DIGITS  (N),
      .REFRESH_DIV (RD),
      .BRIGHT_W    (BW),
      .ACTIVE_LOW  (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t expect_at(input vec_t v, input int p, input logic fr, input logic pd);
      exp_t e;
      int   d;
      int   t;
      logic on;
      d  = p / RD;
      t  = p % RD;
      on = (t >= 1) && (t < (int'(v.bright) + 1) * (RD >> BW)) && !v.dark[d];
      e.an    = on ? ~(4'b0001 << d) : 4'b1111;
      e.seg   = on ? v.glyph[d] : 7'b1111111;
      e.dp    = on ? ~v.dp[d] : 1'b1;
      e.frame = fr;
      e.pend  = pd;
      return e;
   endfunction

   task automatic compare_head(input string name);
      exp_t e;
      exp_t got;
      got = '{an: bus.an_o, seg: bus.seg_o, dp: bus.dp_o, frame: bus.frame_o, pend: bus.pending_o};
      tests++;
      if (sb.size() == 0) begin
         failed++;
         $display("FAIL %s: scoreboard empty, got an=%b seg=%b", name, got.an, got.seg);
      end else begin
         e = sb.pop_front();
         if (got != e) begin
            failed++;
            $display("FAIL %s: got an=%b seg=%b dp=%b frame=%b pend=%b, expected an=%b seg=%b dp=%b frame=%b pend=%b",
                     name, got.an, got.seg, got.dp, got.frame, got.pend,
                     e.an, e.seg, e.dp, e.frame, e.pend);
         end
      end
   endtask

   task automatic drive_load(input vec_t v);
      bus.value_i = v.value;
      bus.dp_i    = v.dp;
      bus.blank_i = v.blank;
      bus.load_i  = 1'b1;
   endtask

   // Entered on the negedge right after the edge that put the scan at digit 0, tcnt 0.
   // Loads 'a' at iteration la and 'b' at lb (-1 disables); la==62 lands on the boundary.
   task automatic check_frame(input int tag, input vec_t cur, input int la, input vec_t a,
                              input int lb, input vec_t b);
      logic pd;
      bus.brightness_i = cur.bright;
      bus.lzb_en_i     = cur.lzb;
      for (int p = 0; p < FRM; p++) begin
         @(posedge clk);
         #1;
         if (p == la)      drive_load(a);
         else if (p == lb) drive_load(b);
         else              bus.load_i = 1'b0;
         pd = ((la >= 0) && (p > la) && (p < FRM - 1)) || ((lb >= 0) && (p > lb) && (p < FRM - 1));
         sb.push_back(expect_at(cur, p, p == FRM - 1, pd));
         @(negedge clk);
         compare_head($sformatf("scan%0d/p%0d", tag, p));
      end
   endtask

   task automatic check_reset_state(input string name);
      sb.push_back('{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, frame: 1'b0, pend: 1'b0});
      compare_head(name);
   endtask

   initial begin
      zero_v = '{16'h0000, 4'b0000, 4'b0000, 1'b0, 2'd3,
                 {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b0000};
      vecs[0]  = '{16'h1F80, 4'b0000, 4'b0000, 1'b0, 2'd3,
                   {7'b1111001, 7'b0001110, 7'b0000000, 7'b1000000}, 4'b0000};
      vecs[1]  = '{16'h1F80, 4'b0000, 4'b0000, 1'b0, 2'd0,
                   {7'b1111001, 7'b0001110, 7'b0000000, 7'b1000000}, 4'b0000};
      vecs[2]  = '{16'h1F80, 4'b0000, 4'b0000, 1'b0, 2'd1,
                   {7'b1111001, 7'b0001110, 7'b0000000, 7'b1000000}, 4'b0000};
      vecs[3]  = '{16'h0040, 4'b0000, 4'b0000, 1'b1, 2'd3,
                   {7'b1111111, 7'b1111111, 7'b0011001, 7'b1000000}, 4'b1100};
      vecs[4]  = '{16'h0040, 4'b0100, 4'b0000, 1'b1, 2'd2,
                   {7'b1111111, 7'b1000000, 7'b0011001, 7'b1000000}, 4'b1000};
      vecs[5]  = '{16'h2345, 4'b0000, 4'b0000, 1'b1, 2'd3,
                   {7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010}, 4'b0000};
      vecs[6]  = '{16'h6789, 4'b1010, 4'b0000, 1'b0, 2'd3,
                   {7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000}, 4'b0000};
      vecs[7]  = '{16'hABCD, 4'b0000, 4'b0101, 1'b0, 2'd3,
                   {7'b0001000, 7'b1111111, 7'b1000110, 7'b1111111}, 4'b0101};
      vecs[8]  = '{16'hABCD, 4'b0000, 4'b0000, 1'b0, 2'd3,
                   {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, 4'b0000};
      vecs[9]  = '{16'hE000, 4'b0000, 4'b0000, 1'b1, 2'd3,
                   {7'b0000110, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b0000};
      vecs[10] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 2'd1,
                   {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1110};

      rst_n            = 1'b0;
      bus.value_i      = '0;
      bus.dp_i         = '0;
      bus.blank_i      = '0;
      bus.load_i       = 1'b0;
      bus.lzb_en_i     = 1'b0;
      bus.brightness_i = 2'd3;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;

      // Each frame checks the vector loaded during the previous frame.
      check_frame(100, zero_v, 10, vecs[0], -1, zero_v);
      for (int i = 1; i < 11; i++)
         check_frame(i - 1, vecs[i-1], 10 + i, vecs[i], -1, zero_v);

      // Two loads in one frame: last wins, display holds until the boundary.
      check_frame(10, vecs[10], 3, vecs[0], 40, vecs[6]);
      // Load on the boundary cycle goes straight to the shadow.
      check_frame(6, vecs[6], FRM - 2, vecs[9], -1, zero_v);
      check_frame(9, vecs[9], -1, zero_v, -1, zero_v);

      // Reset mid-frame with a staged load pending.
      @(posedge clk);
      #1;
      drive_load(vecs[1]);
      @(posedge clk);
      #1;
      bus.load_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if (bus.pending_o !== 1'b1) begin
         failed++;
         $display("FAIL pend_before_rst: got %b, expected 1", bus.pending_o);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_state("midframe_reset");
      rst_n = 1'b1;
      check_frame(200, zero_v, -1, zero_v, -1, zero_v);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

`default_nettype wire
